mcs4_fetch_seq: RTL

- CPU-side bus sequencer for the MCS-4 4-bit multiplexed data bus, directly upstream of the ROM chips.
- Generates `sync` and the 8-phase instruction cycle A1,A2,A3,M1,M2,X1,X2,X3 (encoded 0..7).
- Drives the 12-bit program counter as nibbles in A1..A3, captures OPR/OPA in M1/M2, and asserts `cm_rom` for I/O and SRC instructions.
- Hands each fetched instruction to the execute unit and accepts jump targets and X-phase data from it.

---
 rtl/mcs4_fetch_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mcs4_fetch_seq.sv
// MCS-4 CPU-side bus sequencer: generates the 8-phase instruction cycle, drives
// the PC onto the multiplexed nibble bus, captures OPR/OPA and decodes cm_rom.
module mcs4_fetch_seq #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sync,
  output logic [2:0]  icyc,
  input  logic [3:0]  dbus_in,
  output logic [3:0]  dbus_out,
  output logic        dbus_oe,
  output logic        cm_rom,
  output logic        instr_vld,
  output logic [3:0]  instr_opr,
  output logic [3:0]  instr_opa,
  output logic [11:0] instr_pc,
  input  logic [3:0]  x2_data,
  input  logic        x2_oe,
  output logic [3:0]  io_rd_data,
  output logic        io_rd_vld,
  input  logic        pc_load,
  input  logic [11:0] pc_load_val
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [11:0] pc_q, pc_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  iopr_q, iopr_d;
  logic [3:0]  iopa_q, iopa_d;
  logic [11:0] ipc_q, ipc_d;
  logic [3:0]  io_data_q, io_data_d;

  logic        rd_sel;
  logic        src_sel;

  // The instruction fields are re-registered at the M2 edge so they stay
  // stable from X1 to the next X1, while opr_q is already overwritten in M1.
  assign rd_sel  = (iopr_q == 4'hE) && iopa_q[3];
  assign src_sel = (iopr_q == 4'h2) && iopa_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_X3;
      pc_q      <= RESET_PC;
      opr_q     <= '0;
      iopr_q    <= '0;
      iopa_q    <= '0;
      ipc_q     <= '0;
      io_data_q <= '0;
    end else begin
      phase_q   <= phase_d;
      pc_q      <= pc_d;
      opr_q     <= opr_d;
      iopr_q    <= iopr_d;
      iopa_q    <= iopa_d;
      ipc_q     <= ipc_d;
      io_data_q <= io_data_d;
    end
  end

  always_comb begin
    phase_d   = phase_e'(phase_q + 3'd1);
    pc_d      = pc_q;
    opr_d     = opr_q;
    iopr_d    = iopr_q;
    iopa_d    = iopa_q;
    ipc_d     = ipc_q;
    io_data_d = io_data_q;
    case (phase_q)
      PH_M1: opr_d = dbus_in;
      PH_M2: begin
        iopr_d = opr_q;
        iopa_d = dbus_in;
        ipc_d  = pc_q;
        pc_d   = pc_q + 12'd1;
      end
      PH_X2: if (rd_sel) io_data_d = dbus_in;
      PH_X3: if (pc_load) pc_d = pc_load_val;
      default: ;
    endcase
  end

  always_comb begin
    sync      = 1'b0;
    dbus_out  = '0;
    dbus_oe   = 1'b0;
    cm_rom    = 1'b0;
    instr_vld = 1'b0;
    io_rd_vld = 1'b0;
    case (phase_q)
      PH_A1: begin dbus_out = pc_q[3:0];  dbus_oe = 1'b1; end
      PH_A2: begin dbus_out = pc_q[7:4];  dbus_oe = 1'b1; end
      PH_A3: begin dbus_out = pc_q[11:8]; dbus_oe = 1'b1; end
      PH_M2: cm_rom = (opr_q == 4'hE);
      PH_X1: instr_vld = 1'b1;
      PH_X2: begin
        dbus_out = x2_data;
        dbus_oe  = x2_oe && !rd_sel;
        cm_rom   = src_sel;
      end
      PH_X3: begin
        sync      = 1'b1;
        io_rd_vld = rd_sel;
      end
      default: ;
    endcase
  end

  assign icyc       = phase_q;
  assign instr_opr  = iopr_q;
  assign instr_opa  = iopa_q;
  assign instr_pc   = ipc_q;
  assign io_rd_data = io_data_q;

endmodule
